program_loader: RTL

Synthesizable loader that sits between the hex-word source (file reader in simulation, UART/host link in hardware) and the instruction/data memory write port. It accepts a stream of 32-bit words over a valid/ready handshake, writes them to consecutive memory addresses starting at a base address, and keeps a running word count and additive checksum. It reports completion, or an error on address-space overflow.

---
 rtl/loader_pkg.sv | 14 +
 rtl/program_loader.sv | 101 ++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default widths.
package loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/program_loader.sv
// Streams valid/ready words into consecutive memory addresses from BASE_ADDR,
// tracking word count and additive checksum; flags overflow of the address space.
module program_loader
   import loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [DATA_WIDTH-1:0] checksum
);

   // One more bit than the address so a completely full memory is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]   sum_q, sum_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   // Ready depends only on state and count so the source never sees a combinational loop.
   assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH);

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no branch can infer a latch.
      state_d = state_q;
      count_d = count_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LOAD;
               count_d = '0;
               sum_d   = '0;
            end
         end
         ST_LOAD: begin
            if (in_valid && in_ready) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + count_q[ADDR_WIDTH-1:0];
               wdata_d = in_data;
               count_d = count_q + (ADDR_WIDTH+1)'(1);
               sum_d   = sum_q + in_data;
               if (in_last) state_d = ST_DONE;
            end else if (in_valid) begin
               // Source still pushing with the memory full: refuse rather than drop.
               state_d = ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop load from pre-edge values.
         state_q <= state_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_count = count_q;
   assign checksum   = sum_q;
   assign busy       = (state_q == ST_LOAD);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);

endmodule
